fetch_decode_ctrl: RTL and testbench

//  Mano-computer timing and control front end: 4-bit sequence counter (SC), T0..T15 timing decode,
//  S (run) and R (interrupt-cycle) flip-flops, fetch/decode/interrupt-cycle sequencing.

---
 rtl/mano_pkg.sv | 30 +++
 rtl/seq_counter.sv | 45 ++++
 rtl/fetch_decode_ctrl.sv | 158 +++++++++++++++
 tb/tb_fetch_decode_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mano_pkg.sv
// Shared definitions for the Mano-computer timing and control front end.
//   - bus_sel_e : common-bus source select codes
//   - ScW       : default sequence-counter width
//   - T*Idx     : timing-signal indices used by the fetch/interrupt sequencing
//   - onehot3   : 3-to-8 one-hot decode of the opcode field
package mano_pkg;

  localparam int unsigned ScW = 4;

  typedef enum logic [2:0] {
    BusNone = 3'd0,
    BusAr   = 3'd1,
    BusPc   = 3'd2,
    BusDr   = 3'd3,
    BusAc   = 3'd4,
    BusIr   = 3'd5,
    BusTr   = 3'd6,
    BusMem  = 3'd7
  } bus_sel_e;

  localparam int unsigned T0Idx = 0;
  localparam int unsigned T1Idx = 1;
  localparam int unsigned T2Idx = 2;
  localparam int unsigned T3Idx = 3;

  function automatic logic [7:0] onehot3(input logic [2:0] op);
    return 8'b1 << op;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Sequence counter with increment and synchronous clear, plus one-hot decode.
//   clk_i  : clock, rising edge
//   rst_i  : asynchronous active-high reset (SC <= 0)
//   clr_i  : synchronous clear, wins over inr_i
//   inr_i  : increment (wraps at 2**SC_W-1)
//   sc_o   : counter value
//   t_o    : one-hot decode of sc_o (ungated)
module seq_counter #(
  parameter int unsigned SC_W = 4
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic                 inr_i,
  output logic [SC_W-1:0]      sc_o,
  output logic [2**SC_W-1:0]   t_o
);

  logic [SC_W-1:0] sc_d, sc_q;

  always_comb begin
    sc_d = sc_q;
    if (clr_i) begin
      sc_d = '0;
    end else if (inr_i) begin
      sc_d = sc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sc_q <= '0;
    end else begin
      sc_q <= sc_d;
    end
  end

  always_comb begin
    t_o       = '0;
    t_o[sc_q] = 1'b1;
  end

  assign sc_o = sc_q;

endmodule

// File: rtl/fetch_decode_ctrl.sv
// Mano-computer timing and control front end.
// Sequences fetch (R=0) and interrupt cycle (R=1) over T0..T2, then hands T3+ to the
// execute unit, which returns EXEC_DONE to restart fetch.
//   CLK, CLR          : clock, asynchronous active-high reset
//   START, HLT        : set / clear the run flop S (HLT wins)
//   IR, IEN, FGI, FGO : instruction register, interrupt enable, I/O flags
//   EXEC_DONE         : execute unit finished, clears SC while EXEC
//   T, D, I, S, R     : timing one-hot, opcode decode, indirect bit, run, interrupt cycle
//   EXEC              : execute phase (S & SC>=3)
//   BUS_SEL + strobes : register/memory controls, combinational from (S, R, SC)
module fetch_decode_ctrl
  import mano_pkg::*;
#(
  parameter int unsigned SC_W = ScW,
  parameter int unsigned IR_W = 16
) (
  input  logic               CLK,
  input  logic               CLR,
  input  logic               START,
  input  logic               HLT,
  input  logic [IR_W-1:0]    IR,
  input  logic               IEN,
  input  logic               FGI,
  input  logic               FGO,
  input  logic               EXEC_DONE,
  output logic [2**SC_W-1:0] T,
  output logic [7:0]         D,
  output logic               I,
  output logic               S,
  output logic               R,
  output logic               EXEC,
  output logic [2:0]         BUS_SEL,
  output logic               AR_LD,
  output logic               AR_NCLR,
  output logic               PC_INR,
  output logic               PC_NCLR,
  output logic               IR_LD,
  output logic               TR_LD,
  output logic               MEM_RD,
  output logic               MEM_WR,
  output logic               IEN_CLR
);

  logic [SC_W-1:0]      sc;
  logic [2**SC_W-1:0]   t_raw;
  logic                 sc_clr;
  logic                 s_d, s_q, r_d, r_q, i_d, i_q;
  logic [7:0]           d_d, d_q;
  logic                 t0, t1, t2;
  logic                 unused_ir;

  assign unused_ir = ^IR[IR_W-5:0];

  // Timing is only meaningful while running; gating here freezes every strobe when S=0.
  assign t0   = s_q & t_raw[T0Idx];
  assign t1   = s_q & t_raw[T1Idx];
  assign t2   = s_q & t_raw[T2Idx];
  assign EXEC = s_q & (sc >= SC_W'(T3Idx));

  // Interrupt cycle ends at T2; execute ends on EXEC_DONE. Both restart at T0.
  assign sc_clr = (EXEC & EXEC_DONE) | (r_q & t2);

  seq_counter #(
    .SC_W (SC_W)
  ) u_seq_counter (
    .clk_i (CLK),
    .rst_i (CLR),
    .clr_i (sc_clr),
    .inr_i (s_q),
    .sc_o  (sc),
    .t_o   (t_raw)
  );

  always_comb begin
    s_d = s_q;
    if (HLT) begin
      s_d = 1'b0;
    end else if (START) begin
      s_d = 1'b1;
    end

    r_d = r_q;
    if (r_q & t2) begin
      r_d = 1'b0;
    end else if (EXEC & IEN & (FGI | FGO)) begin
      r_d = 1'b1;
    end

    i_d = i_q;
    d_d = d_q;
    if (~r_q & t2) begin
      i_d = IR[IR_W-1];
      d_d = onehot3(IR[IR_W-2 -: 3]);
    end
  end

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      s_q <= 1'b0;
      r_q <= 1'b0;
      i_q <= 1'b0;
      d_q <= '0;
    end else begin
      s_q <= s_d;
      r_q <= r_d;
      i_q <= i_d;
      d_q <= d_d;
    end
  end

  always_comb begin
    BUS_SEL = BusNone;
    AR_LD   = 1'b0;
    AR_NCLR = 1'b1;
    PC_INR  = 1'b0;
    PC_NCLR = 1'b1;
    IR_LD   = 1'b0;
    TR_LD   = 1'b0;
    MEM_RD  = 1'b0;
    MEM_WR  = 1'b0;
    IEN_CLR = 1'b0;
    if (!r_q) begin
      if (t0) begin
        BUS_SEL = BusPc;
        AR_LD   = 1'b1;
      end else if (t1) begin
        BUS_SEL = BusMem;
        MEM_RD  = 1'b1;
        IR_LD   = 1'b1;
        PC_INR  = 1'b1;
      end else if (t2) begin
        BUS_SEL = BusIr;
        AR_LD   = 1'b1;
      end
    end else begin
      // Save return address at M[0], then jump to 1.
      if (t0) begin
        AR_NCLR = 1'b0;
        BUS_SEL = BusPc;
        TR_LD   = 1'b1;
      end else if (t1) begin
        BUS_SEL = BusTr;
        MEM_WR  = 1'b1;
        PC_NCLR = 1'b0;
      end else if (t2) begin
        PC_INR  = 1'b1;
        IEN_CLR = 1'b1;
      end
    end
  end

  assign T = s_q ? t_raw : '0;
  assign D = d_q;
  assign I = i_q;
  assign S = s_q;
  assign R = r_q;

endmodule

// File: tb/tb_fetch_decode_ctrl.sv
// Self-checking bench for fetch_decode_ctrl: directed scenarios plus randomized run
// compared cycle by cycle against a behavioural reference model.
module tb_fetch_decode_ctrl;

  logic        CLK = 1'b0;
  logic        CLR = 1'b1;
  logic        start = 1'b0, hlt = 1'b0, ien = 1'b0, fgi = 1'b0, fgo = 1'b0, exec_done = 1'b0;
  logic [15:0] ir = '0;
  logic [15:0] T;
  logic [7:0]  D;
  logic        I, S, R, EXEC;
  logic [2:0]  BUS_SEL;
  logic        AR_LD, AR_NCLR, PC_INR, PC_NCLR, IR_LD, TR_LD, MEM_RD, MEM_WR, IEN_CLR;

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state: run flag, timing step number, interrupt flag, decoded opcode.
  bit       m_s, m_r, m_i;
  int       m_sc;
  bit [7:0] m_d;

  always #5 CLK = ~CLK;

  fetch_decode_ctrl dut (
    .CLK(CLK), .CLR(CLR), .START(start), .HLT(hlt), .IR(ir), .IEN(ien), .FGI(fgi), .FGO(fgo),
    .EXEC_DONE(exec_done), .T(T), .D(D), .I(I), .S(S), .R(R), .EXEC(EXEC), .BUS_SEL(BUS_SEL),
    .AR_LD(AR_LD), .AR_NCLR(AR_NCLR), .PC_INR(PC_INR), .PC_NCLR(PC_NCLR), .IR_LD(IR_LD),
    .TR_LD(TR_LD), .MEM_RD(MEM_RD), .MEM_WR(MEM_WR), .IEN_CLR(IEN_CLR)
  );

  task automatic model_reset();
    m_s = 0; m_r = 0; m_i = 0; m_sc = 0; m_d = 8'h00;
  endtask

  // One clock edge of the machine, described as the micro-operation rules.
  task automatic model_edge();
    bit in_exec;
    int nsc;
    in_exec = m_s && (m_sc >= 3);
    if (m_s) begin
      nsc = (m_sc + 1) % 16;
      if (in_exec && exec_done) nsc = 0;
      if (m_r && m_sc == 2) nsc = 0;
      if (!m_r && m_sc == 2) begin
        m_i = ir[15];
        m_d = 8'h01 << ir[14:12];
      end
      if (m_r && m_sc == 2) m_r = 0;
      else if (in_exec && ien && (fgi || fgo)) m_r = 1;
      m_sc = nsc;
    end
    if (hlt) m_s = 0;
    else if (start) m_s = 1;
  endtask

  function automatic logic [39:0] exp_vec();
    logic [15:0] t;
    logic [2:0]  bus;
    logic ar_ld, ar_nclr, pc_inr, pc_nclr, ir_ld, tr_ld, mem_rd, mem_wr, ien_clr;
    t = m_s ? (16'h1 << m_sc) : 16'h0;
    bus = 3'd0; ar_ld = 0; ar_nclr = 1; pc_inr = 0; pc_nclr = 1;
    ir_ld = 0; tr_ld = 0; mem_rd = 0; mem_wr = 0; ien_clr = 0;
    if (m_s && !m_r) begin
      if (m_sc == 0) begin bus = 3'd2; ar_ld = 1; end
      if (m_sc == 1) begin bus = 3'd7; mem_rd = 1; ir_ld = 1; pc_inr = 1; end
      if (m_sc == 2) begin bus = 3'd5; ar_ld = 1; end
    end else if (m_s && m_r) begin
      if (m_sc == 0) begin ar_nclr = 0; bus = 3'd2; tr_ld = 1; end
      if (m_sc == 1) begin bus = 3'd6; mem_wr = 1; pc_nclr = 0; end
      if (m_sc == 2) begin pc_inr = 1; ien_clr = 1; end
    end
    return {t, m_d, m_i, m_s, m_r, (m_s && m_sc >= 3), bus, ar_ld, ar_nclr, pc_inr, pc_nclr,
            ir_ld, tr_ld, mem_rd, mem_wr, ien_clr};
  endfunction

  function automatic logic [39:0] obs_vec();
    return {T, D, I, S, R, EXEC, BUS_SEL, AR_LD, AR_NCLR, PC_INR, PC_NCLR, IR_LD, TR_LD,
            MEM_RD, MEM_WR, IEN_CLR};
  endfunction

  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    CLR = 1'b1;
    @(posedge CLK);
    #1;
    CLR = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++;
    if (obs_vec() !== 40'h00_0000_00A0) begin
      n_fail++; $display("FAIL reset_state: got %h want %h", obs_vec(), 40'h00_0000_00A0);
    end
    // Mid-T1 asynchronous reset.
    start = 1; step(); start = 0; step();
    n_cmp++;
    if (T !== 16'h0002) begin n_fail++; $display("FAIL reset_pre_t1: T=%h want 0002", T); end
    #2 CLR = 1'b1;
    #1;
    n_cmp++;
    if (obs_vec() !== 40'h00_0000_00A0) begin
      n_fail++; $display("FAIL reset_async: got %h want %h", obs_vec(), 40'h00_0000_00A0);
    end
    @(posedge CLK); #1; CLR = 1'b0; model_reset();
  endtask

  task automatic test_fetch();
    do_reset();
    ir = 16'h7800; start = 1; step(); start = 0;
    n_cmp++;
    if (!(T === 16'h1 && AR_LD === 1 && BUS_SEL === 3'd2)) begin
      n_fail++; $display("FAIL fetch_t0: T=%h AR_LD=%b BUS=%0d want 0001/1/2", T, AR_LD, BUS_SEL);
    end
    step();
    n_cmp++;
    if ({MEM_RD, IR_LD, PC_INR, BUS_SEL} !== {3'b111, 3'd7}) begin
      n_fail++; $display("FAIL fetch_t1: got %b want 111111", {MEM_RD, IR_LD, PC_INR, BUS_SEL});
    end
    step();
    n_cmp++;
    if ({AR_LD, BUS_SEL} !== {1'b1, 3'd5}) begin
      n_fail++; $display("FAIL fetch_t2: got %b want 1101", {AR_LD, BUS_SEL});
    end
    step();
    n_cmp++;
    if ({D, I, EXEC} !== {8'h80, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL fetch_t3: D/I/EXEC=%h/%b/%b want 80/0/1", D, I, EXEC);
    end
    n_cmp++;
    if (obs_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL fetch_model: got %h want %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_indirect();
    do_reset();
    ir = 16'h9123; start = 1; step(); start = 0;
    repeat (3) step();
    n_cmp++;
    if ({D, I} !== {8'h02, 1'b1}) begin
      n_fail++; $display("FAIL indirect_decode: D/I=%h/%b want 02/1", D, I);
    end
    step();
    exec_done = 1; step(); exec_done = 0;
    n_cmp++;
    if ({T, AR_LD, BUS_SEL, EXEC} !== {16'h0001, 1'b1, 3'd2, 1'b0}) begin
      n_fail++; $display("FAIL exec_done_restart: T=%h AR_LD=%b BUS=%0d EXEC=%b",
                         T, AR_LD, BUS_SEL, EXEC);
    end
  endtask

  task automatic test_interrupt();
    do_reset();
    ir = 16'h1000; ien = 1; start = 1; step(); start = 0;
    repeat (3) step();
    fgi = 1; exec_done = 1; step(); fgi = 0; exec_done = 0;
    n_cmp++;
    if ({R, T, AR_NCLR, TR_LD, BUS_SEL} !== {1'b1, 16'h0001, 1'b0, 1'b1, 3'd2}) begin
      n_fail++; $display("FAIL intr_t0: R=%b T=%h AR_NCLR=%b TR_LD=%b", R, T, AR_NCLR, TR_LD);
    end
    step();
    n_cmp++;
    if ({MEM_WR, BUS_SEL, PC_NCLR, MEM_RD} !== {1'b1, 3'd6, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL intr_t1: MEM_WR=%b BUS=%0d PC_NCLR=%b", MEM_WR, BUS_SEL, PC_NCLR);
    end
    step();
    n_cmp++;
    if ({PC_INR, IEN_CLR, AR_LD} !== 3'b110) begin
      n_fail++; $display("FAIL intr_t2: PC_INR=%b IEN_CLR=%b AR_LD=%b want 110",
                         PC_INR, IEN_CLR, AR_LD);
    end
    ien = 0; step();
    n_cmp++;
    if ({R, T, AR_LD, BUS_SEL} !== {1'b0, 16'h0001, 1'b1, 3'd2}) begin
      n_fail++; $display("FAIL intr_return: R=%b T=%h AR_LD=%b", R, T, AR_LD);
    end
  endtask

  task automatic test_halt();
    do_reset();
    start = 1; step(); start = 0;
    hlt = 1; step(); hlt = 0;
    for (int k = 0; k < 5; k++) begin
      n_cmp++;
      if ({S, T, MEM_RD, IR_LD, PC_INR} !== 20'h0) begin
        n_fail++; $display("FAIL halt_frozen[%0d]: S=%b T=%h", k, S, T);
      end
      step();
    end
    start = 1; step(); start = 0;
    n_cmp++;
    if ({S, T, MEM_RD, IR_LD} !== {1'b1, 16'h0002, 2'b11}) begin
      n_fail++; $display("FAIL halt_resume: S=%b T=%h MEM_RD=%b", S, T, MEM_RD);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] want;
    do_reset();
    ir = 16'h2000; start = 1; step(); start = 0;
    for (int k = 1; k <= 16; k++) begin
      step();
      want = 16'h1 << (k % 16);
      n_cmp++;
      if (T !== want) begin
        n_fail++; $display("FAIL wrap[%0d]: T=%h want %h", k, T, want);
      end
    end
    n_cmp++;
    if ({AR_LD, BUS_SEL} !== {1'b1, 3'd2}) begin
      n_fail++; $display("FAIL wrap_fetch: AR_LD=%b BUS=%0d", AR_LD, BUS_SEL);
    end
    start = 1; hlt = 1; step(); start = 0; hlt = 0;
    n_cmp++;
    if ({S, T} !== 17'h0) begin
      n_fail++; $display("FAIL start_hlt: S=%b T=%h want 0/0000", S, T);
    end
  endtask

  task automatic test_random();
    do_reset();
    start = 1;
    for (int k = 0; k < 600; k++) begin
      step();
      n_cmp++;
      if (obs_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d]: got %h want %h", k, obs_vec(), exp_vec());
      end
      start     = ($urandom_range(0, 7) == 0);
      hlt       = ($urandom_range(0, 23) == 0);
      exec_done = ($urandom_range(0, 3) == 0);
      ien       = $urandom_range(0, 1);
      fgi       = ($urandom_range(0, 5) == 0);
      fgo       = ($urandom_range(0, 7) == 0);
      ir        = 16'($urandom);
    end
    start = 0; hlt = 0; exec_done = 0; ien = 0; fgi = 0; fgo = 0;
  endtask

  initial begin
    model_reset();
    test_reset();
    test_fetch();
    test_indirect();
    test_interrupt();
    test_halt();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
